// File: rtl/delay_line_pipe_if.sv
// Bundle of stream, control and status signals for delay_line_pipe.
// The depth_sel member exists only when DLY_RUNTIME_DEPTH_EN is defined.
interface delay_line_pipe_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic [CNT_W-1:0] in_flight;
`ifdef DLY_RUNTIME_DEPTH_EN
  logic [CNT_W-1:0] depth_sel;
`endif

  modport master (
`ifdef DLY_RUNTIME_DEPTH_EN
    output depth_sel,
`endif
    output en, flush, data_in, valid_in,
    input  data_out, valid_out, in_flight
  );

  modport slave (
`ifdef DLY_RUNTIME_DEPTH_EN
    input  depth_sel,
`endif
    input  en, flush, data_in, valid_in,
    output data_out, valid_out, in_flight
  );
endinterface

// File: rtl/delay_line_pipe.sv
// WIDTH-bit, DEPTH-stage delay line with stall, flush and in-flight beat counter.
// Optional macro DLY_RUNTIME_DEPTH_EN adds a runtime output tap select (depth_sel).
module delay_line_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  delay_line_pipe_if.slave dl
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] s_p [DEPTH];
  logic [DEPTH-1:0] v_p;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  int               tap;

  function automatic int tap_sel(input logic [CNT_W-1:0] sel);
    if (sel == '0 || int'(sel) > DEPTH) return DEPTH - 1;
    return int'(sel) - 1;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [DEPTH-1:0] vv, input int k);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i < k) n = n + CNT_W'(vv[i]);
    return n;
  endfunction

`ifdef DLY_RUNTIME_DEPTH_EN
  always_comb tap = tap_sel(dl.depth_sel);
`else
  always_comb tap = DEPTH - 1;
`endif

  // Only beats entering and leaving through the active tap change the count.
  always_comb cnt_next = cnt + CNT_W'(dl.valid_in) - CNT_W'(v_p[tap]);

  // Stage boundary: s_p/v_p registers, stage 0 fed from the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) s_p[i] <= '0;
      v_p <= '0;
      cnt <= '0;
    end else if (dl.flush) begin
      v_p <= '0;
      cnt <= '0;
    end else if (dl.en) begin
      s_p[0] <= dl.data_in;
      v_p[0] <= dl.valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        s_p[i] <= s_p[i-1];
        v_p[i] <= v_p[i-1];
      end
      cnt <= cnt_next;
    end
  end

  assign dl.data_out  = s_p[tap];
  assign dl.valid_out = v_p[tap];
  assign dl.in_flight = cnt;

  a_cnt_matches_valid: assert property (@(posedge clk) disable iff (rst)
    cnt == popcnt(v_p, tap + 1));
endmodule

// File: tb/tb_delay_line_pipe.sv
// Directed bench for delay_line_pipe (WIDTH=16, DEPTH=4): ramp, stall, flush, reset, bubbles.
// The depth_sel steps run only when DLY_RUNTIME_DEPTH_EN is defined.
module tb_delay_line_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  delay_line_pipe_if #(.WIDTH(16), .DEPTH(4)) dif ();

  delay_line_pipe #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .dl (dif)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int ramp_if  [12] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
  int bub_vin  [9]  = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
  int bub_vout [9]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
  int bub_if   [9]  = '{1, 1, 2, 3, 2, 2, 1, 0, 0};

  initial begin
    rst = 1'b1;
    dif.en = 1'b1;
    dif.flush = 1'b0;
    dif.data_in = '0;
    dif.valid_in = 1'b0;
`ifdef DLY_RUNTIME_DEPTH_EN
    dif.depth_sel = 3'd4;
`endif
    step();
    step();
    chk("rst_data", 32'(dif.data_out), 32'h0);
    chk("rst_valid", 32'(dif.valid_out), 32'h0);
    chk("rst_if", 32'(dif.in_flight), 32'h0);
    rst = 1'b0;

    // Ramp: 8 valid beats, then 4 invalid cycles carrying garbage data.
    for (int c = 1; c <= 12; c++) begin
      dif.valid_in = (c <= 8);
      dif.data_in  = (c <= 8) ? 16'(c) : 16'(32'hE0 + c);
      step();
      chk($sformatf("ramp_valid[%0d]", c), 32'(dif.valid_out), 32'((c >= 4) && (c <= 11)));
      if (c >= 4 && c <= 11)
        chk($sformatf("ramp_data[%0d]", c), 32'(dif.data_out), 32'(c - 3));
      chk($sformatf("ramp_if[%0d]", c), 32'(dif.in_flight), 32'(ramp_if[c-1]));
    end

    // Stall: two beats in, five frozen cycles, then drain.
    dif.valid_in = 1'b1; dif.data_in = 16'h0021; step();
    dif.data_in = 16'h0022; step();
    dif.en = 1'b0; dif.data_in = 16'h0077;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("stall_if[%0d]", c), 32'(dif.in_flight), 32'd2);
      chk($sformatf("stall_valid[%0d]", c), 32'(dif.valid_out), 32'd0);
      chk($sformatf("stall_data[%0d]", c), 32'(dif.data_out), 32'hEB);
    end
    dif.en = 1'b1; dif.valid_in = 1'b0; dif.data_in = 16'h0000;
    step();
    chk("stall_post1_valid", 32'(dif.valid_out), 32'd0);
    step();
    chk("stall_post2_valid", 32'(dif.valid_out), 32'd1);
    chk("stall_post2_data", 32'(dif.data_out), 32'h21);
    chk("stall_post2_if", 32'(dif.in_flight), 32'd2);
    step();
    chk("stall_post3_data", 32'(dif.data_out), 32'h22);
    chk("stall_post3_if", 32'(dif.in_flight), 32'd1);
    step();
    chk("stall_post4_valid", 32'(dif.valid_out), 32'd0);
    chk("stall_post4_if", 32'(dif.in_flight), 32'd0);

    // Flush a full line together with an incoming 0xFF beat.
    dif.valid_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      dif.data_in = 16'(32'hA0 + c);
      step();
    end
    chk("full_if", 32'(dif.in_flight), 32'd4);
    chk("full_data", 32'(dif.data_out), 32'hA0);
    dif.flush = 1'b1; dif.data_in = 16'h00FF;
    step();
    chk("flush_if", 32'(dif.in_flight), 32'd0);
    chk("flush_valid", 32'(dif.valid_out), 32'd0);
    chk("flush_data_hold", 32'(dif.data_out), 32'hA0);
    dif.flush = 1'b0; dif.valid_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      dif.data_in = 16'(32'hC0 + c);
      step();
      chk($sformatf("flush_drain_valid[%0d]", c), 32'(dif.valid_out), 32'd0);
      chk($sformatf("flush_drain_if[%0d]", c), 32'(dif.in_flight), 32'd0);
    end

    // Reset with three beats in flight, then reset combined with flush and en.
    dif.valid_in = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      dif.data_in = 16'(32'hB0 + c);
      step();
    end
    chk("pre_rst_if", 32'(dif.in_flight), 32'd3);
    rst = 1'b1; dif.valid_in = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_data", 32'(dif.data_out), 32'h0);
    chk("midrst_valid", 32'(dif.valid_out), 32'h0);
    chk("midrst_if", 32'(dif.in_flight), 32'h0);
    dif.valid_in = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      dif.data_in = 16'(32'hD0 + c);
      step();
    end
    chk("pre_rst2_data", 32'(dif.data_out), 32'hD1);
    rst = 1'b1; dif.flush = 1'b1; dif.en = 1'b1;
    step();
    rst = 1'b0; dif.flush = 1'b0; dif.valid_in = 1'b0;
    chk("rstflush_data", 32'(dif.data_out), 32'h0);
    chk("rstflush_valid", 32'(dif.valid_out), 32'h0);
    chk("rstflush_if", 32'(dif.in_flight), 32'h0);

    // Bubbles: valid 1,0,1,1,0 with data 0x11..0x15.
    for (int c = 1; c <= 9; c++) begin
      dif.valid_in = bub_vin[c-1][0];
      dif.data_in  = (c <= 5) ? 16'(32'h10 + c) : 16'h0000;
      step();
      chk($sformatf("bub_valid[%0d]", c), 32'(dif.valid_out), 32'(bub_vout[c-1]));
      if (c >= 4 && c <= 8)
        chk($sformatf("bub_data[%0d]", c), 32'(dif.data_out), 32'(32'h10 + c - 3));
      chk($sformatf("bub_if[%0d]", c), 32'(dif.in_flight), 32'(bub_if[c-1]));
    end

`ifdef DLY_RUNTIME_DEPTH_EN
    // Runtime tap: depth 2, then 0 and 7 clamp to 4.
    dif.depth_sel = 3'd2;
    dif.valid_in = 1'b1; dif.data_in = 16'h005A; step();
    dif.valid_in = 1'b0; dif.data_in = 16'h0000;
    chk("rt2_c1_valid", 32'(dif.valid_out), 32'd0);
    step();
    chk("rt2_c2_valid", 32'(dif.valid_out), 32'd1);
    chk("rt2_c2_data", 32'(dif.data_out), 32'h5A);
    for (int sel = 0; sel < 2; sel++) begin
      dif.flush = 1'b1; step(); dif.flush = 1'b0;
      dif.depth_sel = (sel == 0) ? 3'd0 : 3'd7;
      dif.valid_in = 1'b1; dif.data_in = 16'h005A; step();
      dif.valid_in = 1'b0; dif.data_in = 16'h0000;
      for (int c = 2; c <= 4; c++) begin
        step();
        chk($sformatf("rtclamp%0d_valid[%0d]", sel, c), 32'(dif.valid_out), 32'(c == 4));
      end
      chk($sformatf("rtclamp%0d_data", sel), 32'(dif.data_out), 32'h5A);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
